// File: rtl/data_memory_access.sv
// Load/store sequencer: issues one data-bus transaction per memory op,
// extracts and extends loads, and drives stall, misaligned and fault.
// Ports: clock/reset (async, active low); access* from EX/MEM; flush
// from hazard control; misaligned, stallControl, loadDataValid,
// loadData, accessFault to hazard/trap control; mem* data-memory bus.
// Optional DATA_MEMORY_TIMEOUT_EN: watchdog of TIMEOUT_CYCLES cycles.
module data_memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        accessValid,
    input  logic        accessWrite,
    input  logic [1:0]  accessSize,
    input  logic        accessUnsigned,
    input  logic [31:0] accessAddress,
    input  logic [31:0] accessStoreData,
    input  logic        flush,
    output logic        misaligned,
    output logic        stallControl,
    output logic        loadDataValid,
    output logic [31:0] loadData,
    output logic        accessFault,
    output logic        memRequest,
    output logic        memWrite,
    output logic [31:0] memAddress,
    output logic [3:0]  memByteEnable,
    output logic [31:0] memWriteData,
    input  logic        memReady,
    input  logic        memResponseValid,
    input  logic [31:0] memReadData
);

    typedef enum logic [2:0] {
        IDLE, REQUEST, RESPONSE, DRAIN, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  offset_q, offset_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ldata_q, ldata_d;
    logic        ldv_q, ldv_d;
    logic        fault_q, fault_d;
    logic        start;
    logic        timeout;
    logic [31:0] shifted;
    logic [31:0] extracted;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    always_comb begin
        misaligned = 1'b0;
        if (accessValid) begin
            unique case (accessSize)
                2'b00:   misaligned = 1'b0;
                2'b01:   misaligned = accessAddress[0];
                2'b10:   misaligned = |accessAddress[1:0];
                default: misaligned = 1'b1;
            endcase
        end
    end

    assign start = accessValid && !misaligned && !flush;

    // Gated by reset so the stall request is 0 while reset is held.
    assign stallControl = reset && ((state_q == IDLE && start)
                       || state_q == REQUEST
                       || state_q == RESPONSE
                       || state_q == DRAIN);

    // Combinational on flush: a request is withdrawn in a flush cycle.
    assign memRequest = (state_q == REQUEST) && !flush;

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = accessStoreData;
        unique case (accessSize)
            2'b00: begin
                be_new    = 4'b0001 << accessAddress[1:0];
                wdata_new = {4{accessStoreData[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << accessAddress[1:0];
                wdata_new = {2{accessStoreData[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = accessStoreData;
            end
        endcase
    end

    assign shifted = memReadData >> {offset_q, 3'b000};

    always_comb begin
        extracted = shifted;
        unique case (size_q)
            2'b00: extracted = unsigned_q ? {24'd0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: extracted = unsigned_q ? {16'd0, shifted[15:0]}
                             : {{16{shifted[15]}}, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

`ifdef DATA_MEMORY_TIMEOUT_EN
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] count_q, count_d;

    assign timeout = (count_q == LIMIT);

    // Restart on every entry to a wait state, count while staying.
    always_comb begin
        count_d = 8'd0;
        if (state_d == REQUEST || state_d == RESPONSE
            || state_d == DRAIN) begin
            count_d = (state_d != state_q) ? 8'd0 : count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count_q <= 8'd0;
        else        count_q <= count_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        write_d    = write_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        ldata_d    = ldata_q;
        ldv_d      = 1'b0;
        fault_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = REQUEST;
                    offset_d   = accessAddress[1:0];
                    size_d     = accessSize;
                    unsigned_d = accessUnsigned;
                    write_d    = accessWrite;
                    addr_d     = {accessAddress[31:2], 2'b00};
                    be_d       = be_new;
                    wdata_d    = wdata_new;
                end
            end
            REQUEST: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (memReady) begin
                    state_d = write_q ? DONE : RESPONSE;
                end else if (timeout) begin
                    state_d = IDLE;
                    fault_d = 1'b1;
                end
            end
            RESPONSE: begin
                if (flush) begin
                    state_d = memResponseValid ? IDLE : DRAIN;
                end else if (memResponseValid) begin
                    state_d = DONE;
                    ldata_d = extracted;
                    ldv_d   = 1'b1;
                end else if (timeout) begin
                    state_d = IDLE;
                    fault_d = 1'b1;
                end
            end
            DRAIN: begin
                if (memResponseValid) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                    fault_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            offset_q   <= 2'd0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= 32'd0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            ldata_q    <= 32'd0;
            ldv_q      <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            ldata_q    <= ldata_d;
            ldv_q      <= ldv_d;
            fault_q    <= fault_d;
        end
    end

    assign memWrite      = write_q;
    assign memAddress    = addr_q;
    assign memByteEnable = be_q;
    assign memWriteData  = wdata_q;
    assign loadData      = ldata_q;
    assign loadDataValid = ldv_q;
    assign accessFault   = fault_q;

endmodule

// File: tb/tb_data_memory_access.sv
// Directed self-checking bench for data_memory_access.
// One task per scenario; inputs driven on the falling edge.
module tb_data_memory_access;

    logic        clock = 1'b0;
    logic        reset;
    logic        accessValid, accessWrite, accessUnsigned, flush;
    logic [1:0]  accessSize;
    logic [31:0] accessAddress, accessStoreData;
    logic        misaligned, stallControl, loadDataValid, accessFault;
    logic [31:0] loadData, memAddress, memWriteData, memReadData;
    logic        memRequest, memWrite, memReady, memResponseValid;
    logic [3:0]  memByteEnable;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    data_memory_access #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .accessValid(accessValid), .accessWrite(accessWrite),
        .accessSize(accessSize), .accessUnsigned(accessUnsigned),
        .accessAddress(accessAddress),
        .accessStoreData(accessStoreData), .flush(flush),
        .misaligned(misaligned), .stallControl(stallControl),
        .loadDataValid(loadDataValid), .loadData(loadData),
        .accessFault(accessFault), .memRequest(memRequest),
        .memWrite(memWrite), .memAddress(memAddress),
        .memByteEnable(memByteEnable), .memWriteData(memWriteData),
        .memReady(memReady), .memResponseValid(memResponseValid),
        .memReadData(memReadData)
    );

    task automatic quiet();
        accessValid = 0; accessWrite = 0; accessSize = 2'b00;
        accessUnsigned = 0; accessAddress = 0; accessStoreData = 0;
        flush = 0; memReady = 0; memResponseValid = 0; memReadData = 0;
    endtask

    task automatic op(input logic w, input logic [1:0] sz,
                      input logic u, input logic [31:0] a,
                      input logic [31:0] d);
        accessValid = 1; accessWrite = w; accessSize = sz;
        accessUnsigned = u; accessAddress = a; accessStoreData = d;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 0;
        op(0, 2'b10, 0, 32'h100, 0);
        #1;
        n_cmp++;
        if (stallControl !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_stall got %b want 0", stallControl);
        end
        n_cmp++;
        if ({memRequest, memWrite, loadDataValid, accessFault} !== 4'b0) begin
            n_bad++;
            $display("FAIL rst_flags got %b want 0000",
                     {memRequest, memWrite, loadDataValid, accessFault});
        end
        n_cmp++;
        if ({memAddress, memByteEnable, memWriteData, loadData} !== '0) begin
            n_bad++;
            $display("FAIL rst_data got %h %h %h %h want 0", memAddress,
                     memByteEnable, memWriteData, loadData);
        end
        @(negedge clock);
        quiet();
        reset = 1;
    endtask

    task automatic test_lb(input logic u, input logic [31:0] exp);
        @(negedge clock);
        op(0, 2'b00, u, 32'h1003, 0);
        memReady = 1;
        #1;
        n_cmp++;
        if (stallControl !== 1'b1 || memRequest !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_c0 got stall=%b req=%b want 1 0",
                     stallControl, memRequest);
        end
        @(negedge clock); #1;
        n_cmp++;
        if (memRequest !== 1'b1 || memWrite !== 1'b0
            || memAddress !== 32'h1000 || memByteEnable !== 4'b1000) begin
            n_bad++;
            $display("FAIL lb_req got req=%b w=%b a=%h be=%b want 1 0 1000 1000",
                     memRequest, memWrite, memAddress, memByteEnable);
        end
        @(negedge clock);
        memReady = 0; memResponseValid = 1; memReadData = 32'h8000_0000;
        #1;
        n_cmp++;
        if (stallControl !== 1'b1 || loadDataValid !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_resp got stall=%b ldv=%b want 1 0",
                     stallControl, loadDataValid);
        end
        @(negedge clock);
        quiet();
        #1;
        n_cmp++;
        if (loadDataValid !== 1'b1 || loadData !== exp
            || stallControl !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_done u=%b got ldv=%b data=%h stall=%b want 1 %h 0",
                     u, loadDataValid, loadData, stallControl, exp);
        end
        @(negedge clock); #1;
        n_cmp++;
        if (loadDataValid !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_pulse got %b want 0", loadDataValid);
        end
    endtask

    task automatic test_sh_wait();
        int stalls = 0;
        int ldvs = 0;
        @(negedge clock);
        op(1, 2'b01, 0, 32'h2002, 32'hABCD_1234);
        for (int c = 0; c < 5; c++) begin
            memReady = (c == 3);
            if (c == 4) quiet();
            #1;
            if (stallControl === 1'b1) stalls++;
            if (loadDataValid === 1'b1) ldvs++;
            if (c == 1) begin
                n_cmp++;
                if (memRequest !== 1'b1 || memWrite !== 1'b1
                    || memByteEnable !== 4'b1100
                    || memWriteData !== 32'h1234_1234
                    || memAddress !== 32'h2000) begin
                    n_bad++;
                    $display("FAIL sh_req got req=%b w=%b be=%b wd=%h a=%h",
                             memRequest, memWrite, memByteEnable,
                             memWriteData, memAddress);
                end
            end
            @(negedge clock);
        end
        n_cmp++;
        if (stalls !== 4 || ldvs !== 0) begin
            n_bad++;
            $display("FAIL sh_stall got stalls=%0d ldv=%0d want 4 0",
                     stalls, ldvs);
        end
    endtask

    task automatic test_misaligned();
        int reqs = 0;
        int stalls = 0;
        op(0, 2'b10, 0, 32'h3001, 0);
        memReady = 1;
        #1;
        n_cmp++;
        if (misaligned !== 1'b1) begin
            n_bad++;
            $display("FAIL mis_lw got %b want 1", misaligned);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (c == 1) op(0, 2'b11, 0, 32'h3000, 0);
            #1;
            if (memRequest === 1'b1) reqs++;
            if (stallControl === 1'b1) stalls++;
        end
        n_cmp++;
        if (misaligned !== 1'b1) begin
            n_bad++;
            $display("FAIL mis_size11 got %b want 1", misaligned);
        end
        n_cmp++;
        if (reqs !== 0 || stalls !== 0) begin
            n_bad++;
            $display("FAIL mis_quiet got req=%0d stall=%0d want 0 0",
                     reqs, stalls);
        end
        accessValid = 0;
        #1;
        n_cmp++;
        if (misaligned !== 1'b0) begin
            n_bad++;
            $display("FAIL mis_gate got %b want 0", misaligned);
        end
        @(negedge clock);
        quiet();
    endtask

    task automatic test_flush_drain();
        int ldvs = 0;
        op(0, 2'b10, 0, 32'h4000, 0);
        memReady = 1;
        @(negedge clock);
        @(negedge clock);
        memReady = 0; flush = 1;
        #1;
        n_cmp++;
        if (stallControl !== 1'b1) begin
            n_bad++;
            $display("FAIL fd_flush_stall got %b want 1", stallControl);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            quiet();
            memResponseValid = (c == 1);
            memReadData = 32'h1111_2222;
            #1;
            if (loadDataValid === 1'b1) ldvs++;
            n_cmp++;
            if (stallControl !== 1'b1) begin
                n_bad++;
                $display("FAIL fd_drain_stall c=%0d got %b want 1",
                         c, stallControl);
            end
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            quiet();
            #1;
            if (loadDataValid === 1'b1) ldvs++;
        end
        n_cmp++;
        if (stallControl !== 1'b0 || ldvs !== 0) begin
            n_bad++;
            $display("FAIL fd_end got stall=%b ldv=%0d want 0 0",
                     stallControl, ldvs);
        end
    endtask

    task automatic test_store_flush();
        @(negedge clock);
        op(1, 2'b10, 0, 32'h5000, 32'hDEAD_BEEF);
        @(negedge clock);
        flush = 1; memReady = 1;
        #1;
        n_cmp++;
        if (memRequest !== 1'b0) begin
            n_bad++;
            $display("FAIL sf_req got %b want 0", memRequest);
        end
        @(negedge clock);
        quiet();
        #1;
        n_cmp++;
        if (stallControl !== 1'b0 || memRequest !== 1'b0) begin
            n_bad++;
            $display("FAIL sf_idle got stall=%b req=%b want 0 0",
                     stallControl, memRequest);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        op(0, 2'b10, 0, 32'h7004, 0);
        memReady = 1;
        @(negedge clock);
        @(negedge clock);
        memReady = 0;
        reset = 0;
        #1;
        n_cmp++;
        if ({memRequest, memWrite, loadDataValid, accessFault,
             stallControl} !== 5'b0
            || memAddress !== 32'd0 || memByteEnable !== 4'd0) begin
            n_bad++;
            $display("FAIL rm_out got req=%b st=%b a=%h be=%b want 0",
                     memRequest, stallControl, memAddress, memByteEnable);
        end
        @(negedge clock);
        quiet();
        reset = 1;
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        op(0, 2'b01, 0, 32'h6002, 0);
        memReady = 1;
        @(negedge clock);
        @(negedge clock);
        memReady = 0;
        @(negedge clock);
        memResponseValid = 1; memReadData = 32'h8001_0000;
        @(negedge clock);
        memResponseValid = 0;
        #1;
        n_cmp++;
        if (loadDataValid !== 1'b1 || loadData !== 32'hFFFF_8001) begin
            n_bad++;
            $display("FAIL b2b_lh got ldv=%b data=%h want 1 ffff8001",
                     loadDataValid, loadData);
        end
        @(negedge clock);
        op(1, 2'b00, 0, 32'h6001, 32'h0000_005A);
        memReady = 1;
        #1;
        n_cmp++;
        if (stallControl !== 1'b1 || loadDataValid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_next got stall=%b ldv=%b want 1 0",
                     stallControl, loadDataValid);
        end
        @(negedge clock); #1;
        n_cmp++;
        if (memRequest !== 1'b1 || memByteEnable !== 4'b0010
            || memWriteData !== 32'h5A5A_5A5A
            || memAddress !== 32'h6000) begin
            n_bad++;
            $display("FAIL b2b_sb got req=%b be=%b wd=%h a=%h",
                     memRequest, memByteEnable, memWriteData, memAddress);
        end
        @(negedge clock);
        quiet();
        #1;
        n_cmp++;
        if (stallControl !== 1'b0 || loadDataValid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_done got stall=%b ldv=%b want 0 0",
                     stallControl, loadDataValid);
        end
    endtask

    task automatic test_timeout();
        @(negedge clock);
        op(1, 2'b10, 0, 32'h8000, 32'h1);
`ifdef DATA_MEMORY_TIMEOUT_EN
        for (int c = 0; c < 5; c++) @(negedge clock);
        accessValid = 0;
        #1;
        n_cmp++;
        if (accessFault !== 1'b1 || stallControl !== 1'b0
            || memRequest !== 1'b0) begin
            n_bad++;
            $display("FAIL to_fault got f=%b st=%b req=%b want 1 0 0",
                     accessFault, stallControl, memRequest);
        end
        @(negedge clock); #1;
        n_cmp++;
        if (accessFault !== 1'b0) begin
            n_bad++;
            $display("FAIL to_pulse got %b want 0", accessFault);
        end
`else
        for (int c = 0; c < 101; c++) @(negedge clock);
        #1;
        n_cmp++;
        if (stallControl !== 1'b1 || memRequest !== 1'b1
            || accessFault !== 1'b0) begin
            n_bad++;
            $display("FAIL to_hold got st=%b req=%b f=%b want 1 1 0",
                     stallControl, memRequest, accessFault);
        end
        memReady = 1;
        @(negedge clock);
        quiet();
        #1;
        n_cmp++;
        if (stallControl !== 1'b0) begin
            n_bad++;
            $display("FAIL to_release got %b want 0", stallControl);
        end
`endif
        @(negedge clock);
        quiet();
    endtask

    initial begin
        reset = 0;
        quiet();
        test_reset();
        test_lb(1'b0, 32'hFFFF_FF80);
        test_lb(1'b1, 32'h0000_0080);
        test_sh_wait();
        test_misaligned();
        test_flush_drain();
        test_store_flush();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory_access.md
# data_memory_access

Load/store sequencer between the execute/memory pipeline register and the data-memory bus. It issues one bus transaction per memory instruction and extracts and extends load data. It generates `stallControl`, `loadDataValid` and the misalignment flag consumed by the hazard/trap control unit. Flushes from that unit abort or drain in-flight accesses.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: watchdog limit in cycles. Used only with `DATA_MEMORY_TIMEOUT_EN`. Range 1..255.

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `accessValid`  in  1  EX/MEM holds a valid load or store
- `accessWrite`  in  1  1 = store, 0 = load
- `accessSize`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `accessUnsigned`  in  1  zero-extend load (LBU/LHU)
- `accessAddress`  in  32  byte address
- `accessStoreData`  in  32  store data, right-aligned
- `flush`  in  1  EX/MEM flush from hazard control
- `misaligned`  out  1  combinational: half with addr[0]=1, word with addr[1:0]≠0, or size 11; gated by `accessValid`
- `stallControl`  out  1  combinational pipeline-wide stall request
- `loadDataValid`  out  1  registered one-cycle pulse, load result ready
- `loadData`  out  32  registered extended load result
- `accessFault`  out  1  registered one-cycle watchdog pulse
- `memRequest`  out  1  bus request valid
- `memWrite`  out  1  registered
- `memAddress`  out  32  registered, word-aligned (addr[1:0]=00)
- `memByteEnable`  out  4  registered
- `memWriteData`  out  32  registered, lane-replicated
- `memReady`  in  1  bus accepts the request when `memRequest && memReady`
- `memResponseValid`  in  1  load data valid on `memReadData`
- `memReadData`  in  32  read word

## Operation
- States: IDLE, REQUEST, RESPONSE, DRAIN, DONE.
- IDLE: `accessValid && !misaligned && !flush` latches the address, size, unsigned flag, byte enables and write data. Next state is REQUEST. A misaligned access issues no bus traffic; hazard control traps on `misaligned`.
- REQUEST: `memRequest = !flush`.
  - Accept with store → DONE.
  - Accept with load → RESPONSE.
  - `flush` without accept → IDLE, request withdrawn. Withdrawal is legal only via flush.
- RESPONSE: `memResponseValid` captures the extracted data → DONE. `flush` → DRAIN. If `flush` and `memResponseValid` occur together → IDLE with the data discarded.
- DRAIN: wait for `memResponseValid`, discard it → IDLE, no `loadDataValid`.
- DONE: pulse `loadDataValid` for loads only → IDLE.
- `stallControl` = (IDLE && accessValid && !misaligned && !flush) || REQUEST || RESPONSE || DRAIN. It is 0 in DONE, so the pipeline advances on the DONE edge.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
- Write data:
  - byte: {4{d[7:0]}}
  - half: {2{d[15:0]}}
  - word: d
- Load extraction: shift `memReadData` right by 8·addr[1:0]. Sign-extend bit 7/15, or zero-extend when `accessUnsigned`.
- Reset (`reset`=0, any state): state IDLE; `memRequest`, `memWrite`, `loadDataValid`, `accessFault`, `stallControl` 0; `memAddress`, `memByteEnable`, `memWriteData`, `loadData` 0. An in-flight transaction is abandoned. The bus must be reset in the same domain.

## Timing
- Zero-wait store: op arrives cycle 0 (stall=1), REQUEST+accept cycle 1, DONE cycle 2 (stall=0). Three cycles occupancy.
- Zero-wait load: cycle 0 IDLE, cycle 1 accept, cycle 2 response, cycle 3 DONE with `loadDataValid`=1 and `loadData` valid.
- Each `memReady`/`memResponseValid` wait cycle adds one cycle.
- `misaligned` and `stallControl` are same-cycle combinational outputs. All bus outputs are registered or a state decode gated by `flush`.
- `memRequest` depends combinationally on `flush`, so a store is never accepted in a flush cycle.

## Configuration
- `DATA_MEMORY_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to REQUEST, RESPONSE or DRAIN and increments each cycle spent there.
  - On reaching `TIMEOUT_CYCLES` without progress: `accessFault` pulses for 1 cycle, state goes to IDLE, and no `loadDataValid` is produced.
- Undefined: no counter, `accessFault` tied 0, waits are unbounded.

## Test plan
- LB at 0x1003, read word 0x80_00_00_00, zero waits → `memByteEnable`=1000, `memAddress`=0x1000, `loadDataValid` at cycle 3, `loadData`=0xFFFFFF80. LBU gives 0x00000080.
- SH 0xABCD1234 at 0x2002, `memReady` low 2 cycles → `memByteEnable`=1100, `memWriteData`=0x12341234, stall high 4 cycles, no `loadDataValid`.
- LW at 0x3001 → `misaligned`=1 same cycle, `memRequest` never asserted, state stays IDLE. The same check applies to size 11.
- LW accepted, `flush` in the first RESPONSE cycle, response 2 cycles later → DRAIN, `loadDataValid` stays 0, IDLE after the response, stall held until then.
- Store in REQUEST with `flush`=1 and `memReady`=1 in the same cycle → `memRequest`=0, no write, IDLE next cycle. `reset`=0 mid-RESPONSE → all outputs 0 immediately.
- With `DATA_MEMORY_TIMEOUT_EN` and TIMEOUT_CYCLES=4: `memReady` held 0 → `accessFault` pulses after 4 REQUEST cycles, then IDLE. Without the macro, still stalled after 100 cycles.
